// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: turns PS/2 scan-code bytes into lightbike game commands.
// Parses make / break (F0) / extended (E0) sequences, drops stale prefixes
// after a timeout, suppresses typematic repeat on start and reset keys, and
// buffers each player's direction until the game step strobe so a bike can
// never turn straight back into its own trail.
module ps2_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  CODE_START     = 8'h29,
  parameter logic [7:0]  CODE_RESET     = 8'h76
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       init_dirs,
  input  logic       step,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       start_pulse,
  output logic       reset_pulse,
  output logic [7:0] last_make
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Player-1 key map: {hit, direction}.
  function automatic logic [2:0] p1_key(input logic [7:0] code);
    case (code)
      8'h1D:   return {1'b1, DIR_UP};
      8'h1B:   return {1'b1, DIR_DOWN};
      8'h1C:   return {1'b1, DIR_LEFT};
      8'h23:   return {1'b1, DIR_RIGHT};
      default: return 3'b000;
    endcase
  endfunction

  // Player-2 key map (arrow keys): {hit, direction}.
  function automatic logic [2:0] p2_key(input logic [7:0] code);
    case (code)
      8'h75:   return {1'b1, DIR_UP};
      8'h72:   return {1'b1, DIR_DOWN};
      8'h6B:   return {1'b1, DIR_LEFT};
      8'h74:   return {1'b1, DIR_RIGHT};
      default: return 3'b000;
    endcase
  endfunction

  // Reverse of a direction: flipping bit 1 maps UP<->DOWN and RIGHT<->LEFT.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_s;

  logic             make_s;
  logic             brk_s;
  logic             ext_s;

  logic [1:0]       p1_pend_r;
  logic [1:0]       p2_pend_r;
  logic             start_held_r;
  logic             reset_held_r;

  logic [2:0]       p1_req_s;
  logic [2:0]       p2_req_s;
  logic [1:0]       p1_commit_next_s;
  logic [1:0]       p2_commit_next_s;
  logic             p1_accept_s;
  logic             p2_accept_s;
  logic             start_make_s;
  logic             reset_make_s;
  logic             start_fire_s;
  logic             reset_fire_s;

  assign timeout_s = (cnt_r == CNT_LAST);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Parser next-state: prefix bytes move between states, timeouts drop back to idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (scan_valid && (scan_code == CODE_EXT)) begin
          state_s = ST_EXT;
        end else if (scan_valid && (scan_code == CODE_BRK)) begin
          state_s = ST_BRK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXT: begin
        if (scan_valid) begin
          if (scan_code == CODE_BRK) begin
            state_s = ST_EXT_BRK;
          end else if (scan_code == CODE_EXT) begin
            state_s = ST_EXT;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_EXT;
        end
      end
      ST_BRK, ST_EXT_BRK: begin
        if (scan_valid || timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Parser outputs: classify the current byte as a make (with ext flag) or a break.
  always_comb begin
    make_s = 1'b0;
    brk_s  = 1'b0;
    ext_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (scan_valid && (scan_code != CODE_EXT) && (scan_code != CODE_BRK)) begin
          make_s = 1'b1;
        end else begin
          make_s = 1'b0;
        end
      end
      ST_EXT: begin
        if (scan_valid && (scan_code != CODE_EXT) && (scan_code != CODE_BRK)) begin
          make_s = 1'b1;
          ext_s  = 1'b1;
        end else begin
          make_s = 1'b0;
        end
      end
      ST_BRK, ST_EXT_BRK: begin
        brk_s = scan_valid;
      end
      default: begin
        make_s = 1'b0;
        brk_s  = 1'b0;
      end
    endcase
  end

  // Prefix timeout counter: runs only while waiting mid-sequence without input.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (scan_valid || (state_r == ST_IDLE) || (state_s == ST_IDLE)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Key decode and anti-reverse check against the direction that will be live next cycle.
  always_comb begin
    p1_req_s         = p1_key(scan_code);
    p2_req_s         = p2_key(scan_code);
    p1_commit_next_s = step ? p1_pend_r : p1_dir;
    p2_commit_next_s = step ? p2_pend_r : p2_dir;
    p1_accept_s      = make_s && !ext_s && p1_req_s[2]
                       && (p1_req_s[1:0] != opposite(p1_commit_next_s));
    p2_accept_s      = make_s && p2_req_s[2]
                       && (p2_req_s[1:0] != opposite(p2_commit_next_s));
    start_make_s     = make_s && !ext_s && (scan_code == CODE_START);
    reset_make_s     = make_s && !ext_s && (scan_code == CODE_RESET);
    start_fire_s     = start_make_s && !start_held_r;
    reset_fire_s     = reset_make_s && !reset_held_r;
  end

  // Pending and committed directions; init_dirs overrides step and key requests.
  always_ff @(posedge clk) begin
    if (reset || init_dirs) begin
      p1_dir    <= DIR_RIGHT;
      p2_dir    <= DIR_LEFT;
      p1_pend_r <= DIR_RIGHT;
      p2_pend_r <= DIR_LEFT;
    end else begin
      if (step) begin
        p1_dir <= p1_pend_r;
        p2_dir <= p2_pend_r;
      end else begin
        p1_dir <= p1_dir;
        p2_dir <= p2_dir;
      end
      if (p1_accept_s) begin
        p1_pend_r <= p1_req_s[1:0];
      end else begin
        p1_pend_r <= p1_pend_r;
      end
      if (p2_accept_s) begin
        p2_pend_r <= p2_req_s[1:0];
      end else begin
        p2_pend_r <= p2_pend_r;
      end
    end
  end

  // Start/escape pulses with held flags so typematic repeats do not retrigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_pulse  <= 1'b0;
      reset_pulse  <= 1'b0;
      start_held_r <= 1'b0;
      reset_held_r <= 1'b0;
    end else begin
      start_pulse <= start_fire_s;
      reset_pulse <= reset_fire_s;
      if (start_fire_s) begin
        start_held_r <= 1'b1;
      end else if (brk_s && (scan_code == CODE_START)) begin
        start_held_r <= 1'b0;
      end else begin
        start_held_r <= start_held_r;
      end
      if (reset_fire_s) begin
        reset_held_r <= 1'b1;
      end else if (brk_s && (scan_code == CODE_RESET)) begin
        reset_held_r <= 1'b0;
      end else begin
        reset_held_r <= reset_held_r;
      end
    end
  end

  // Debug copy of the most recent make code.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_make <= 8'h00;
    end else if (make_s) begin
      last_make <= scan_code;
    end else begin
      last_make <= last_make;
    end
  end

endmodule

// File: doc/ps2_cmd_decoder.md
Name: ps2_cmd_decoder

Overview:
- Sits between the PS/2 receiver (keyboard + pulse_gen) and the lightbike game FSM. Turns raw scan-code bytes into clean game commands.
- Parses make, break (F0) and extended (E0) sequences, and suppresses typematic repeat on start and reset.
- Holds both players' directions and commits them only on the game step strobe, so a bike can never reverse into its own trail.

Parameters:
- TIMEOUT_CYCLES, 2500000, number of clk cycles an unfinished prefix (E0/F0) waits for its next byte before it is discarded.
- CODE_START, 8'h29, scan code for space (start/ack).
- CODE_RESET, 8'h76, scan code for escape (reset).

Ports:
- clk  in  1  system clock (DIV_CLK[0] domain).
- reset  in  1  synchronous, active-high reset.
- scan_valid  in  1  single-cycle strobe: scan_code holds a new byte.
- scan_code  in  8  received PS/2 byte.
- init_dirs  in  1  single-cycle strobe from game FSM in state I: load start directions.
- step  in  1  single-cycle strobe: game advanced one grid cell; commit pending directions.
- p1_dir  out  2  committed player-1 direction (UP=0, RIGHT=1, DOWN=2, LEFT=3).
- p2_dir  out  2  committed player-2 direction, same encoding.
- start_pulse  out  1  one-cycle pulse on a fresh space make.
- reset_pulse  out  1  one-cycle pulse on a fresh escape make.
- last_make  out  8  last accepted make code (E0 prefix not included), for SSD debug.

Behaviour:
- Reset values: p1_dir=RIGHT, p2_dir=LEFT, both pending dirs equal their committed dirs, start_pulse=0, reset_pulse=0, last_make=8'h00, parser=IDLE, held flags=0, timeout counter=0.
- Parser states and transitions, all on scan_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(code, ext=0).
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; other byte -> make(code, ext=1), then IDLE.
  - BRK: any byte -> break(code), then IDLE.
  - EXT_BRK: any byte -> break(code), then IDLE.
- Timeout: in EXT, BRK or EXT_BRK the counter increments each cycle without scan_valid. It clears on every scan_valid and on entry to IDLE. On reaching TIMEOUT_CYCLES-1 the parser returns to IDLE and the partial sequence is dropped.
- Make processing (ext is ignored for arrow keys, so numpad arrows also work):
  - last_make <= code on every make.
  - P1 keys: 1D=UP, 1B=DOWN, 1C=LEFT, 23=RIGHT; honoured only when ext=0.
  - P2 keys: 75=UP, 72=DOWN, 6B=LEFT, 74=RIGHT.
  - CODE_START with ext=0: if start_held=0, assert start_pulse for one cycle and set start_held=1; otherwise (typematic repeat) no pulse.
  - CODE_RESET with ext=0: same rule using reset_held and reset_pulse.
  - Unlisted codes update last_make only.
- Break processing: a break of CODE_START clears start_held; a break of CODE_RESET clears reset_held. All other breaks are ignored. Breaks never change last_make or directions.
- Direction rules (per player, evaluated in the same cycle):
  - commit_next = pending if step=1, else committed.
  - A direction request is written to pending unless it equals commit_next XOR 2'b10 (the opposite direction), in which case it is dropped.
  - Several requests between steps: the last accepted one wins.
  - committed <= pending_old on step.
  - Pulse outputs are registered: they appear one cycle after the scan_valid that caused them.
  - Directions are registered: committed changes the cycle after step.
- init_dirs sets pending and committed to RIGHT for P1 and LEFT for P2. It has priority over step and over a same-cycle request.
- reset_pulse does not self-reset this block. Only the reset port does.
- Reset asserted mid-sequence (e.g. after E0) fully restores reset values; the byte that follows is parsed from IDLE.

Test Plan:
- Reset, then scan 1D; step -> p1_dir=0 (UP) one cycle after step; last_make=1D.
- p1_dir=RIGHT, scan 1C (LEFT), step -> p1_dir stays RIGHT; then scan 1B, step -> p1_dir=2.
- p1 committed=RIGHT, pending=UP: assert step and scan 1B (DOWN) in the same cycle -> p1_dir=UP after step; DOWN dropped; next step keeps UP.
- Scan 29, 29, 29 (typematic) -> exactly one start_pulse; then F0 29, then 29 -> a second start_pulse.
- Scan E0 75 -> p2 pending=UP; scan E0 F0 75 -> no change; scan E0 1D -> p1 unchanged, last_make=1D.
- Scan E0, idle TIMEOUT_CYCLES cycles (bench uses 16), scan 76 -> reset_pulse=1, treated as a plain make. Also check that init_dirs in the same cycle as step restores RIGHT/LEFT.
